// File: rtl/mips_processor.sv
// Single-cycle MIPS subset core: ROM instruction store, register file, ALU,
// data RAM and next-PC logic; observed through internal hierarchy only.

module mips_imem #(
   parameter int IMEM_WORDS = 64
) (
   input  logic [31:0] pc,
   output logic [31:0] instr
);
   localparam int AW = $clog2(IMEM_WORDS);
   typedef logic [31:0] rom_t [IMEM_WORDS];

   function automatic rom_t default_rom();
      rom_t r;
      r    = '{default: '0};
      r[0] = 32'h2002_0004;   // addi $2,$0,4
      r[1] = 32'hAC02_0004;   // sw   $2,4($0)
      r[2] = 32'h0800_0002;   // j    0x8
      return r;
   endfunction

   logic [31:0] rom [IMEM_WORDS] = default_rom();
   logic        unused_pc_bits;

   assign instr          = rom[pc[AW+1:2]];
   assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};

   task automatic read_memory(input integer word_index, output logic [31:0] data);
      data = rom[word_index[AW-1:0]];
   endtask
endmodule

module mips_dmem #(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   localparam int AW = $clog2(DMEM_WORDS);

   logic [31:0]   mem [DMEM_WORDS];
   logic [AW-1:0] idx;
   logic          unused_addr_bits;

   // Upper address bits are dropped so out-of-range accesses wrap.
   assign idx              = addr[AW+1:2];
   assign rdata            = mem[idx];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     mem      <= '{default: '0};
      else if (write) mem[idx] <= wdata;
   end

   task automatic read_memory(input integer word_index, output logic [31:0] data);
      data = mem[word_index[AW-1:0]];
   endtask
endmodule

module mips_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] registers [0:31];

   // $0 is never written, so it reads zero without a read-side mux.
   assign rd1 = registers[ra1];
   assign rd2 = registers[ra2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  registers     <= '{default: '0};
      else if (we && wa != 5'd0)   registers[wa] <= wd;
   end
endmodule

module mips_datapath #(
   parameter int          DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   output logic [31:0] pc
);
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] simm, zimm, pc4, br_tgt, jmp_tgt;
   logic [31:0] rs_val, rt_val, mem_addr, mem_rdata, res, next_pc;
   logic        we, mem_we;
   logic [4:0]  wa;

   assign op      = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign shamt   = instr[10:6];
   assign funct   = instr[5:0];
   assign imm     = instr[15:0];
   assign simm    = {{16{imm[15]}}, imm};
   assign zimm    = {16'h0, imm};
   assign pc4     = pc + 32'd4;
   assign br_tgt  = pc4 + {simm[29:0], 2'b00};
   assign jmp_tgt = {pc4[31:28], instr[25:0], 2'b00};
   assign mem_addr = rs_val + simm;

   mips_regfile registerFile (
      .clk (clk), .reset (reset), .ra1 (rs), .ra2 (rt),
      .we (we), .wa (wa), .wd (res), .rd1 (rs_val), .rd2 (rt_val)
   );

   mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) dataMemory (
      .clk (clk), .reset (reset), .addr (mem_addr), .write (mem_we),
      .wdata (rt_val), .rdata (mem_rdata)
   );

   // Decode, ALU and next-PC in one block; unknown encodings fall through as nop.
   always_comb begin
      we      = 1'b0;
      wa      = rt;
      res     = '0;
      mem_we  = 1'b0;
      next_pc = pc4;
      case (op)
         6'h00: begin
            we = 1'b1;
            wa = rd;
            case (funct)
               6'h20, 6'h21: res = rs_val + rt_val;
               6'h22, 6'h23: res = rs_val - rt_val;
               6'h24:        res = rs_val & rt_val;
               6'h25:        res = rs_val | rt_val;
               6'h26:        res = rs_val ^ rt_val;
               6'h27:        res = ~(rs_val | rt_val);
               6'h2a:        res = {31'b0, $signed(rs_val) < $signed(rt_val)};
               6'h2b:        res = {31'b0, rs_val < rt_val};
               6'h00:        res = rt_val << shamt;
               6'h02:        res = rt_val >> shamt;
               6'h03:        res = $signed(rt_val) >>> shamt;
               6'h08: begin
                  we      = 1'b0;
                  next_pc = rs_val;
               end
               default:      we = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin we = 1'b1; res = rs_val + simm; end
         6'h0a: begin we = 1'b1; res = {31'b0, $signed(rs_val) < $signed(simm)}; end
         6'h0b: begin we = 1'b1; res = {31'b0, rs_val < simm}; end
         6'h0c: begin we = 1'b1; res = rs_val & zimm; end
         6'h0d: begin we = 1'b1; res = rs_val | zimm; end
         6'h0e: begin we = 1'b1; res = rs_val ^ zimm; end
         6'h0f: begin we = 1'b1; res = {imm, 16'h0}; end
         6'h23: begin we = 1'b1; res = mem_rdata; end
         6'h2b: mem_we = 1'b1;
         6'h04: if (rs_val == rt_val) next_pc = br_tgt;
         6'h05: if (rs_val != rt_val) next_pc = br_tgt;
         6'h02: next_pc = jmp_tgt;
         6'h03: begin
            next_pc = jmp_tgt;
            we      = 1'b1;
            wa      = 5'd31;
            res     = pc4;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= RESET_PC;
      else        pc <= next_pc;
   end
endmodule

module mips_processor #(
   parameter int          IMEM_WORDS = 64,
   parameter int          DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input logic clk,
   input logic reset
);
   logic [31:0] pc, instr;

   mips_imem #(.IMEM_WORDS(IMEM_WORDS)) instructionMemory (
      .pc (pc), .instr (instr)
   );

   mips_datapath #(.DMEM_WORDS(DMEM_WORDS), .RESET_PC(RESET_PC)) dataPath (
      .clk (clk), .reset (reset), .instr (instr), .pc (pc)
   );
endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: default program trace, ALU/branch,
// jal/jr and mid-run reset, checked through internal hierarchy.

module tb_mips_processor;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   mips_processor dut (.clk(clk), .reset(reset));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct { string name; int idx; logic [31:0] exp; } reg_chk_t;
   typedef struct { logic [31:0] pc; logic [31:0] r2; logic [31:0] m1; } trace_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Called 2 ns after a rising edge; releases on the following falling edge.
   task automatic restart();
      reset = 1'b0;
      #3;
      reset = 1'b1;
   endtask

   task automatic set_word(input int i, input logic [31:0] w);
      dut.instructionMemory.rom[i] = w;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) set_word(i, 32'h0);
   endtask

   task automatic dmem(input int i, output logic [31:0] d);
      dut.dataPath.dataMemory.read_memory(i, d);
   endtask

   function automatic logic [31:0] rf(input int i);
      return dut.dataPath.registerFile.registers[i];
   endfunction

   logic [31:0] alu_prog [18] = '{
      32'h2001FFFF, 32'h0001182B, 32'h0001202A, 32'h10630001,
      32'h20050007, 32'h3C061234, 32'h34C75678, 32'h00074022,
      32'h00084903, 32'h00085102, 32'hAC080008, 32'h8C0B0008,
      32'h14600001, 32'h200C0009, 32'h38EDFFFF, 32'h290E0000,
      32'h00ED7824, 32'h08000011 };

   logic [31:0] jal_prog [6] = '{
      32'h20000005, 32'h0C000004, 32'h20020002, 32'h08000003,
      32'h20030003, 32'h03E00008 };

   initial begin
      logic [31:0] d;
      trace_t   trace [3];
      reg_chk_t tab   [$];

      trace[0] = '{32'h4, 32'h4, 32'h0};
      trace[1] = '{32'h8, 32'h4, 32'h4};
      trace[2] = '{32'h8, 32'h4, 32'h4};

      // Reset state and default ROM contents
      reset = 1'b0;
      #4;
      check("pc_in_reset", dut.dataPath.pc, 32'h0);
      #6;
      reset = 1'b1;
      check("pc_after_release", dut.dataPath.pc, 32'h0);
      for (int i = 0; i < 32; i++) check($sformatf("reg%0d_reset", i), rf(i), 32'h0);
      dut.instructionMemory.read_memory(0, d);
      check("imem0", d, 32'h20020004);
      dut.instructionMemory.read_memory(1, d);
      check("imem1", d, 32'hAC020004);

      // Default program, one edge at a time
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("trace%0d_pc", i), dut.dataPath.pc, trace[i].pc);
         check($sformatf("trace%0d_r2", i), rf(2), trace[i].r2);
         dmem(1, d);
         check($sformatf("trace%0d_mem1", i), d, trace[i].m1);
      end
      repeat (97) tick();
      check("run_r2", rf(2), 32'h4);
      dmem(1, d);
      check("run_mem1", d, 32'h4);
      dmem(0, d);
      check("run_mem0", d, 32'h0);
      check("run_pc", dut.dataPath.pc, 32'h8);
      tick();
      check("run_pc_stable", dut.dataPath.pc, 32'h8);

      // Mid-run asynchronous reset
      reset = 1'b0;
      #1;
      check("midrst_pc", dut.dataPath.pc, 32'h0);
      check("midrst_r2", rf(2), 32'h0);
      dmem(1, d);
      check("midrst_mem1", d, 32'h0);
      tick();
      check("midrst_pc_held", dut.dataPath.pc, 32'h0);
      #3;
      reset = 1'b1;
      tick();
      check("restart_pc1", dut.dataPath.pc, 32'h4);
      check("restart_r2", rf(2), 32'h4);
      dmem(1, d);
      check("restart_mem1_e1", d, 32'h0);
      tick();
      dmem(1, d);
      check("restart_mem1_e2", d, 32'h4);
      check("restart_pc2", dut.dataPath.pc, 32'h8);

      // ALU / branch / load-store program
      clear_rom();
      for (int i = 0; i < 18; i++) set_word(i, alu_prog[i]);
      restart();
      repeat (30) tick();
      tab.push_back('{"alu_r1",  1,  32'hFFFFFFFF});
      tab.push_back('{"alu_r3",  3,  32'h00000001});
      tab.push_back('{"alu_r4",  4,  32'h00000000});
      tab.push_back('{"alu_r5",  5,  32'h00000000});
      tab.push_back('{"alu_r6",  6,  32'h12340000});
      tab.push_back('{"alu_r7",  7,  32'h12345678});
      tab.push_back('{"alu_r8",  8,  32'hEDCBA988});
      tab.push_back('{"alu_r9",  9,  32'hFEDCBA98});
      tab.push_back('{"alu_r10", 10, 32'h0EDCBA98});
      tab.push_back('{"alu_r11", 11, 32'hEDCBA988});
      tab.push_back('{"alu_r12", 12, 32'h00000000});
      tab.push_back('{"alu_r13", 13, 32'h1234A987});
      tab.push_back('{"alu_r14", 14, 32'h00000001});
      tab.push_back('{"alu_r15", 15, 32'h12340000});
      tab.push_back('{"alu_r2",  2,  32'h00000000});
      foreach (tab[i]) check(tab[i].name, rf(tab[i].idx), tab[i].exp);
      check("alu_pc", dut.dataPath.pc, 32'h44);
      dmem(2, d);
      check("alu_mem2", d, 32'hEDCBA988);
      dmem(1, d);
      check("alu_mem1", d, 32'h0);

      // jal / jr and writes to $0
      clear_rom();
      for (int i = 0; i < 6; i++) set_word(i, jal_prog[i]);
      restart();
      tick();
      check("jal_pc1", dut.dataPath.pc, 32'h4);
      check("jal_r0_e1", rf(0), 32'h0);
      tick();
      check("jal_pc2", dut.dataPath.pc, 32'h10);
      check("jal_r31", rf(31), 32'h8);
      tick();
      check("jal_pc3", dut.dataPath.pc, 32'h14);
      tick();
      check("jr_pc", dut.dataPath.pc, 32'h8);
      repeat (5) tick();
      tab.delete();
      tab.push_back('{"jal_r0",  0,  32'h0});
      tab.push_back('{"jal_r31", 31, 32'h8});
      tab.push_back('{"jal_r2",  2,  32'h2});
      tab.push_back('{"jal_r3",  3,  32'h3});
      foreach (tab[i]) check(tab[i].name, rf(tab[i].idx), tab[i].exp);
      check("jal_pc_final", dut.dataPath.pc, 32'hC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mips_processor.md
Name: mips_processor

Overview:
- Single-cycle 32-bit MIPS subset processor: PC, instruction memory, register file, ALU, data memory and control, all in one block with no external data ports.
- Runs the program preloaded in instruction memory.
- Verification observes it through fixed internal hierarchical names.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words.
- DMEM_WORDS, 64, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).

Behaviour:
- Required hierarchy, for bench access:
  - dataPath.pc: 32-bit PC register.
  - dataPath.registerFile.registers[0:31]: 32-bit register array.
  - dataPath.dataMemory: data memory.
  - instructionMemory: instruction memory.
- Both memories provide task read_memory(input integer word_index, output [31:0] data). It returns the word at that index and is zero-time and side-effect free.
- Reset asserted (reset=0), asynchronously:
  - pc = RESET_PC.
  - All 32 registers = 0.
  - All data memory words = 0.
  - Instruction memory is not affected.
- After release, one instruction completes per rising clk edge. The first edge executes the instruction at RESET_PC.
- Instruction memory:
  - Word-addressed by pc[log2(IMEM_WORDS)+1:2]; combinational read; ROM.
  - Default contents:
    - word0 = 32'h20020004: addi $2,$0,4.
    - word1 = 32'hAC020004: sw $2,4($0).
    - word2 = 32'h08000002: j 0x8, a self-loop.
    - All other words = 0 (sll $0,$0,0, which acts as a nop).
- Data memory:
  - Word-addressed by ALU result [log2(DMEM_WORDS)+1:2]; low two address bits ignored.
  - Combinational read; write on rising edge when MemWrite.
  - Out-of-range addresses wrap modulo depth.
- Register file:
  - Two combinational read ports, one write port on rising edge.
  - $0 always reads 0; writes to $0 are discarded.
  - Same-cycle read and write of one register: the read returns the old value.
- Supported instructions; all others execute as nop (PC+4, no state change):
  - R-type, opcode 0: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Arithmetic and width rules:
  - Arithmetic is 32-bit two's-complement wraparound; no overflow exceptions.
  - Signed immediates are sign-extended: addi/addiu/slti/sltiu, load/store offsets, branch offsets.
  - andi/ori/xori zero-extend the immediate.
  - lui places imm in [31:16] with zeros below.
  - slt/slti compare signed; sltu/sltiu compare unsigned. The result is 1 or 0.
  - Shift amount comes from shamt.
- Next-PC logic:
  - Default: PC+4.
  - Taken beq/bne: PC+4+(sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jal writes PC+4 to $31.
  - jr: rs.
- No delay slots, pipelining or hazards.
- The PC wraps naturally at 2^32.
- Reset asserted mid-program aborts the current instruction; no partial register or memory write occurs.

Test Plan:
- Assert reset=0 for 10 ns, release, run 100 cycles of default program:
  - registers[2]=32'h4.
  - dataMemory.read_memory(1)=32'h4.
  - dataMemory.read_memory(0)=0.
  - pc=32'h8, stable thereafter.
- After reset, before the first edge:
  - pc=0 and all registers=0.
  - instructionMemory.read_memory(0)=20020004.
  - instructionMemory.read_memory(1)=AC020004.
- Trace the program one edge at a time:
  - pc sequence 0→4→8→8.
  - $2 becomes 4 after edge 1.
  - Memory word1 becomes 4 after edge 2.
- Load an ALU/branch program. Sequence:
  - addi $1,$0,-1.
  - sltu $3,$0,$1.
  - slt $4,$0,$1.
  - beq $3,$3,+1, over addi $5,$0,7.
  - lui $6,0x1234.
  - Required: $1=FFFFFFFF, $3=1, $4=0, $5=0, $6=12340000.
- Load jal/jr and $0-write program, including addi $0,$0,5:
  - $0 stays 0.
  - jal stores return address in $31.
  - jr returns to it.
- Assert reset=0 mid-run, between clock edges:
  - pc, registers and data memory clear immediately.
  - Execution restarts from 0 after release.
